// File: rtl/i2c_target_regif.sv
// I2C target register front end: decodes address and pointer bytes and maps
// burst writes/reads onto a single-cycle register strobe interface.
`timescale 1ns/1ps
module i2c_target_regif #(
    parameter logic [6:0] I2C_ADDR   = 7'h2A,
    parameter int         NUM_REGS   = 8,
    parameter int         REG_WIDTH  = 8,
    parameter int         ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic                  scl,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_oe,
    output logic                  reg_bank,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [REG_WIDTH-1:0]  reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [REG_WIDTH-1:0]  reg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_PTR,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [REG_WIDTH-2:0]  shreg_q, shreg_d;
    logic                  rw_q, rw_d;
    logic                  got_ack_q, got_ack_d;
    logic                  oe_q, oe_d;
    logic                  bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  wr_done_q, wr_done_d;
    logic                  scl_q, sda_q;

    logic                  scl_rise, scl_fall;
    logic                  start_det, stop_det;
    logic                  byte_done, rd_load;
    logic [REG_WIDTH-1:0]  rx_byte;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda_i;
    assign stop_det  = scl & scl_q & ~sda_q & sda_i;
    assign rx_byte   = {shreg_q, sda_i};
    assign byte_done = scl_rise & (bit_cnt_q == 3'd7);
    assign addr_inc  = (addr_q == LAST_ADDR) ? '0
                     : addr_q + ADDR_WIDTH'(1);

    assign sda_o     = 1'b0;
    assign sda_oe    = oe_q;
    assign reg_bank  = bank_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = rd_load & ena;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            got_ack_q <= 1'b0;
            oe_q      <= 1'b0;
            bank_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            wr_done_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else if (ena) begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            got_ack_q <= got_ack_d;
            oe_q      <= oe_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            wr_done_q <= wr_done_d;
            scl_q     <= scl;
            sda_q     <= sda_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        got_ack_d = got_ack_q;
        oe_d      = oe_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        wr_done_d = 1'b0;
        rd_load   = 1'b0;

        // Write pointer advances the cycle after the strobe.
        if (wr_done_q) begin
            addr_d = addr_inc;
        end

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[REG_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        rw_d    = sda_i;
                        state_d = (rx_byte[7:1] == I2C_ADDR) ? S_ADDR_ACK
                                                             : S_IDLE;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (!rw_q) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_WR_PTR;
                        end else begin
                            rd_load = 1'b1;
                        end
                    end
                end
                S_WR_PTR: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[REG_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        bank_d  = rx_byte[7];
                        addr_d  = rx_byte[ADDR_WIDTH-1:0];
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[REG_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        wdata_d   = rx_byte;
                        we_d      = ~bank_q;
                        wr_done_d = 1'b1;
                        state_d   = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            oe_d      = 1'b0;
                            got_ack_d = 1'b0;
                            state_d   = S_RD_ACK;
                        end else begin
                            oe_d      = ~shreg_q[REG_WIDTH-2];
                            shreg_d   = {shreg_q[REG_WIDTH-3:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_i) begin
                            state_d = S_IDLE;
                        end else begin
                            got_ack_d = 1'b1;
                        end
                    end else if (scl_fall && got_ack_q) begin
                        rd_load = 1'b1;
                    end
                end
            endcase
        end

        // Fetch next read byte: MSB goes out on this same SCL fall.
        if (rd_load) begin
            shreg_d   = reg_rdata[REG_WIDTH-2:0];
            oe_d      = ~reg_rdata[REG_WIDTH-1];
            addr_d    = addr_inc;
            bit_cnt_d = '0;
            state_d   = S_RD_DATA;
        end
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: directed and randomized I2C transactions
// compared against a register-level model of pointer and config bank.
`timescale 1ns/1ps
module tb_i2c_target_regif;

    localparam int Q = 4;

    typedef struct packed {
        logic       bank;
        logic [2:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic       scl = 1'b1;
    logic       ctl_sda = 1'b1;
    logic       sda_line;
    logic       sda_o, sda_oe, reg_bank, reg_we, reg_re;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;

    logic [7:0] cfg_bank [8] = '{default: 8'h00};
    logic [7:0] sta_bank [8];
    logic [7:0] mdl_cfg [8];
    ev_t        we_log [512];
    ev_t        re_log [512];
    int         we_n = 0;
    int         re_n = 0;
    int         overlap = 0;
    int         long_pulse = 0;
    int         oe_cnt = 0;
    logic       we_prev = 1'b0;
    logic       re_prev = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         m_addr;
    logic       m_bank;

    always #5 clk = ~clk;

    assign sda_line  = ctl_sda & ~sda_oe;
    assign reg_rdata = reg_bank ? sta_bank[reg_addr] : cfg_bank[reg_addr];

    i2c_target_regif dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .scl       (scl),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .reg_bank  (reg_bank),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata)
    );

    // Register bank emulation and strobe logging.
    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (reg_we && reg_re) overlap++;
        if ((reg_we && we_prev) || (reg_re && re_prev)) long_pulse++;
        we_prev = reg_we;
        re_prev = reg_re;
        if (reg_we && we_n < 512) begin
            we_log[we_n] = '{reg_bank, reg_addr, reg_wdata};
            we_n++;
            cfg_bank[reg_addr] = reg_wdata;
        end
        if (reg_re && re_n < 512) begin
            re_log[re_n] = '{reg_bank, reg_addr, reg_rdata};
            re_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        ctl_sda = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        ctl_sda = 1'b0; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic stop_c();
        ctl_sda = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        ctl_sda = 1'b1; tick(Q);
    endtask

    task automatic bit_w(input logic b);
        ctl_sda = b; tick(Q);
        scl = 1'b1;  tick(Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic byte_w(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(b[i]);
        ctl_sda = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        ack = ~sda_line;
        scl = 1'b0;     tick(Q);
    endtask

    task automatic byte_r(input logic ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            ctl_sda = 1'b1; tick(Q);
            scl = 1'b1;     tick(Q);
            b[i] = sda_line;
            scl = 1'b0;     tick(Q);
        end
        bit_w(~ack);
    endtask

    task automatic do_write(input string tag, input logic [7:0] ptr,
                            input logic [7:0] data [$]);
        logic a;
        int   nack = 0;
        int   w0 = we_n;
        int   rd = we_n;
        start_c();
        byte_w(8'h54, a); if (!a) nack++;
        byte_w(ptr, a);   if (!a) nack++;
        foreach (data[i]) begin
            byte_w(data[i], a);
            if (!a) nack++;
        end
        stop_c();
        chk({tag, " nacks"}, 32'(nack), 32'd0);
        m_bank = ptr[7];
        m_addr = int'(ptr[2:0]);
        chk({tag, " we count"}, 32'(we_n - w0),
            m_bank ? 32'd0 : 32'(data.size()));
        foreach (data[i]) begin
            if (!m_bank) begin
                mdl_cfg[m_addr] = data[i];
                if (rd < we_n) begin
                    chk({tag, " we event"},
                        32'({we_log[rd].bank, we_log[rd].addr, we_log[rd].data}),
                        32'({1'b0, 3'(m_addr), data[i]}));
                    rd++;
                end
            end
            m_addr = (m_addr + 1) % 8;
        end
        if (!m_bank)
            chk({tag, " ptr"}, 32'({reg_bank, reg_addr}),
                32'({1'b0, 3'(m_addr)}));
    endtask

    task automatic do_read(input string tag, input logic [7:0] ptr,
                           input int n);
        logic       a;
        logic [7:0] b;
        logic [7:0] exp;
        int         nack = 0;
        int         r0 = re_n;
        start_c();
        byte_w(8'h54, a); if (!a) nack++;
        byte_w(ptr, a);   if (!a) nack++;
        start_c();
        byte_w(8'h55, a); if (!a) nack++;
        chk({tag, " nacks"}, 32'(nack), 32'd0);
        m_bank = ptr[7];
        m_addr = int'(ptr[2:0]);
        for (int i = 0; i < n; i++) begin
            exp = m_bank ? sta_bank[m_addr] : mdl_cfg[m_addr];
            byte_r(i < n - 1, b);
            chk({tag, " rdata"}, 32'(b), 32'(exp));
            if (r0 + i < re_n)
                chk({tag, " re event"},
                    32'({re_log[r0+i].bank, re_log[r0+i].addr}),
                    32'({m_bank, 3'(m_addr)}));
            m_addr = (m_addr + 1) % 8;
        end
        chk({tag, " sda released"}, 32'(sda_oe), 32'd0);
        stop_c();
        chk({tag, " re count"}, 32'(re_n - r0), 32'(n));
    endtask

    initial begin
        logic       a;
        logic [7:0] q [$];
        logic [7:0] b;
        logic [7:0] exp;
        int         w0, r0, o0;

        for (int i = 0; i < 8; i++) begin
            sta_bank[i] = 8'($urandom);
            mdl_cfg[i]  = 8'h00;
        end
        tick(3);
        chk("reset sda_o", 32'(sda_o), 32'd0);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset reg_we", 32'(reg_we), 32'd0);
        chk("reset reg_re", 32'(reg_re), 32'd0);
        chk("reset reg_wdata", 32'(reg_wdata), 32'd0);
        chk("reset ptr", 32'({reg_bank, reg_addr}), 32'd0);
        rstb = 1'b1;
        tick(4);

        q = '{8'h3C};
        do_write("single", 8'h00, q);
        q = '{8'h11, 8'h22, 8'h33};
        do_write("burst wrap", 8'h06, q);

        sta_bank[0] = 8'hCA;
        sta_bank[1] = 8'h10;
        do_read("combined", 8'h80, 2);

        w0 = we_n; r0 = re_n; o0 = oe_cnt;
        start_c();
        byte_w(8'h56, a);
        byte_w(8'h00, a);
        stop_c();
        chk("mismatch oe", 32'(oe_cnt - o0), 32'd0);
        chk("mismatch we", 32'(we_n - w0), 32'd0);
        chk("mismatch re", 32'(re_n - r0), 32'd0);

        q = '{8'hFF};
        do_write("status wr", 8'h81, q);

        w0 = we_n;
        start_c();
        byte_w(8'h54, a);
        chk("abort addr ack", 32'(a), 32'd1);
        byte_w(8'h02, a);
        bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
        stop_c();
        chk("abort we", 32'(we_n - w0), 32'd0);
        chk("abort ptr", 32'({reg_bank, reg_addr}), 32'd2);

        for (int t = 0; t < 12; t++) begin
            logic [7:0] p;
            int         n;
            p = {1'($urandom_range(0, 3) == 0), 4'h0,
                 3'($urandom_range(0, 7))};
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                q.delete();
                for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                do_write("rand wr", p, q);
            end else begin
                do_read("rand rd", p, n);
            end
        end

        sta_bank[3] = 8'h00;
        start_c();
        byte_w(8'h54, a);
        byte_w(8'h83, a);
        start_c();
        byte_w(8'h55, a);
        chk("pre-reset sda_oe", 32'(sda_oe), 32'd1);
        rstb = 1'b0;
        #1;
        chk("async rst sda_oe", 32'(sda_oe), 32'd0);
        chk("async rst reg_re", 32'(reg_re), 32'd0);
        chk("async rst reg_we", 32'(reg_we), 32'd0);
        chk("async rst ptr", 32'({reg_bank, reg_addr}), 32'd0);
        tick(2);
        rstb = 1'b1;
        ctl_sda = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        start_c();
        byte_w(8'h55, a);
        chk("post-reset ack", 32'(a), 32'd1);
        exp = mdl_cfg[0];
        byte_r(1'b0, b);
        chk("post-reset rdata", 32'(b), 32'(exp));
        stop_c();

        chk("we/re overlap", 32'(overlap), 32'd0);
        chk("strobe width", 32'(long_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
